// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide scheduler: MDUOp encodings,
// FSM state codes and the latency counter width.
package mdu_pkg;

    localparam logic [2:0] MDU_MULTU = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_DIVU  = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div result generator: (A, B, MDUOp) -> {hi, lo}.
// Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_is_div,
    output logic        o_div0
);

    logic        w_signed;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    always_comb begin
        o_is_div = (i_op[2:1] == MDU_DIVU[2:1]);
        w_signed = i_op[0];
        o_div0   = o_is_div && (i_b == 32'd0);

        if (w_signed)
            w_prod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        else
            w_prod = {32'd0, i_a} * {32'd0, i_b};

        w_abs_a = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
        w_abs_b = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
        // Divisor forced to 1 on B==0; that result is never committed.
        w_div_b = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
        w_uq    = w_abs_a / w_div_b;
        w_ur    = w_abs_a % w_div_b;
        w_q     = (w_signed && (i_a[31] ^ i_b[31])) ? (32'd0 - w_uq) : w_uq;
        w_r     = (w_signed && i_a[31]) ? (32'd0 - w_ur) : w_ur;

        if (o_is_div) begin
            o_hi = w_r;
            o_lo = w_q;
        end else begin
            o_hi = w_prod[63:32];
            o_lo = w_prod[31:0];
        end
    end

endmodule

// File: rtl/mdu_sched.sv
// E-stage HI/LO scheduler: multi-cycle mult/div FSM, mthi/mtlo, D-stage stall, sticky err.
// Optional macro MDU_DIV0_FAST_EN: divide by zero finishes after one busy cycle.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        exc_flush,
    input  logic        MD_D,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err,
    output logic [0:0]  o_dbg_state
);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_wr;
    logic             r_err;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_is_div;
    logic             w_div0;
    logic             w_busy;
    logic             w_start_ok;
    logic             w_hi_wr;
    logic             w_lo_wr;
    logic [CNT_W-1:0] w_lat;

    mdu_arith u_arith (
        .i_a      (A),
        .i_b      (B),
        .i_op     (MDUOp),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo),
        .o_is_div (w_is_div),
        .o_div0   (w_div0)
    );

    always_comb begin
        w_busy     = (r_state == ST_RUN);
        w_start_ok = start   && !exc_flush && !w_busy;
        w_hi_wr    = HIWrite && !exc_flush && !w_busy;
        w_lo_wr    = LOWrite && !exc_flush && !w_busy;
`ifdef MDU_DIV0_FAST_EN
        if (w_div0)
            w_lat = CNT_W'(1);
        else
            w_lat = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
`else
        w_lat = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Any MDU request that arrives while an op is in flight is dropped and flagged.
            if (w_busy && (start || HIWrite || LOWrite))
                r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= w_lat;
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_wr <= !w_div0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // mthi/mtlo only occur while idle, so they never race a commit.
            if (w_hi_wr)
                r_hi <= A;
            if (w_lo_wr)
                r_lo <= A;
        end
    end

    assign busy        = w_busy;
    assign stall_d     = MD_D && (w_busy || start);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: a driver advances a behavioural HI/LO model and queues
// the expected outputs; a monitor on the falling edge pops and compares them.
module tb_mdu_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic        HIWrite;
    logic        LOWrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        exc_flush;
    logic        MD_D;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    logic [0:0]  dbg_state;

    mdu_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .MDUOp       (MDUOp),
        .HIWrite     (HIWrite),
        .LOWrite     (LOWrite),
        .A           (A),
        .B           (B),
        .exc_flush   (exc_flush),
        .MD_D        (MD_D),
        .busy        (busy),
        .stall_d     (stall_d),
        .hi          (hi),
        .lo          (lo),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        reset = 1'b1; start = 1'b0; MDUOp = 3'b000; HIWrite = 1'b0; LOWrite = 1'b0;
        A = '0; B = '0; exc_flush = 1'b0; MD_D = 1'b0;
    end

    // ---------------- scoreboard ----------------
    // entry layout: {stall_d, busy, err, hi, lo}
    logic [66:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // ---------------- reference model ----------------
    bit          m_valid = 0;
    int          m_left;
    bit          m_commit;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_err;

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rhi, output logic [31:0] rlo);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = int'(a);
        sb = int'(b);
        rhi = '0;
        rlo = '0;
        case (op)
            3'b000: begin up = longint'(a) * longint'(b); rhi = up[63:32]; rlo = up[31:0]; end
            3'b001: begin sp = longint'(sa) * longint'(sb); rhi = sp[63:32]; rlo = sp[31:0]; end
            3'b010: if (b != 0) begin rlo = a / b; rhi = a % b; end
            default: if (b != 0) begin
                if (sa == 32'sh8000_0000 && sb == -1) begin
                    rlo = 32'h8000_0000; rhi = 32'h0;
                end else begin
                    rlo = sa / sb; rhi = sa % sb;
                end
            end
        endcase
    endfunction

    task automatic model_step(input logic st, input logic [2:0] op, input logic hw, input logic lw,
                              input logic [31:0] a, input logic [31:0] b, input logic fl,
                              input logic rs);
        bit is_div;
        if (rs) begin
            m_valid = 1; m_left = 0; m_commit = 0; m_hi = '0; m_lo = '0; m_err = 0;
            return;
        end
        if (m_left > 0) begin
            if (st || hw || lw) m_err = 1;
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (!fl) begin
            if (st) begin
                is_div = op[1];
                ref_op(op, a, b, m_phi, m_plo);
                m_commit = !(is_div && b == 0);
                m_left = is_div ? DIV_LAT : MULT_LAT;
`ifdef MDU_DIV0_FAST_EN
                if (is_div && b == 0) m_left = 1;
`endif
            end
            if (hw) m_hi = a;
            if (lw) m_lo = a;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic st, input logic [2:0] op, input logic hw, input logic lw,
                         input logic [31:0] a, input logic [31:0] b, input logic fl,
                         input logic md, input logic rs);
        @(posedge clk);
        #1;
        start = st; MDUOp = op; HIWrite = hw; LOWrite = lw; A = a; B = b;
        exc_flush = fl; MD_D = md; reset = rs;
        if (m_valid)
            exp_q.push_back({md & ((m_left > 0) | st), 1'(m_left > 0), 1'(m_err), m_hi, m_lo});
        model_step(st, op, hw, lw, a, b, fl, rs);
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) cycle(0, 3'b000, 0, 0, $urandom, $urandom, 0, md, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor ----------------
    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        logic [66:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check1("stall_d", 32'(stall_d), 32'(e[66]));
                check1("busy",    32'(busy),    32'(e[65]));
                check1("err",     32'(err),     32'(e[64]));
                check1("hi",      hi,           e[63:32]);
                check1("lo",      lo,           e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic st, fl, hw, lw;
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 1, 1);
        idle(2, 0);

        // mult -1*2, with the D-stage MD instruction held to watch the stall
        cycle(1, 3'b001, 0, 0, 32'hFFFF_FFFF, 32'd2, 0, 1, 0);
        idle(MULT_LAT + 2, 1);
        // multu 0xFFFFFFFF*2
        cycle(1, 3'b000, 0, 0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        idle(MULT_LAT + 1, 0);
        // div -7/2 and divu 7/2
        cycle(1, 3'b011, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        idle(DIV_LAT + 1, 0);
        cycle(1, 3'b010, 0, 0, 32'd7, 32'd2, 0, 0, 0);
        idle(DIV_LAT + 1, 0);
        // overflow divide and divide by zero
        cycle(1, 3'b011, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        idle(DIV_LAT + 1, 0);
        cycle(1, 3'b011, 0, 0, 32'd99, 32'd0, 0, 1, 0);
        idle(DIV_LAT + 1, 1);
        // mthi/mtlo, then flushed start and flushed mthi
        cycle(0, 3'b000, 1, 1, 32'h1234_5678, 0, 0, 0, 0);
        cycle(1, 3'b001, 0, 0, 32'd3, 32'd4, 1, 1, 0);
        cycle(0, 3'b000, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 0);
        idle(3, 0);
        // reset on the third RUN cycle
        cycle(1, 3'b001, 0, 0, 32'd6, 32'd7, 0, 0, 0);
        idle(2, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        idle(3, 0);
        // start on the last busy cycle is a violation
        cycle(1, 3'b000, 0, 0, 32'd5, 32'd5, 0, 0, 0);
        idle(MULT_LAT - 1, 0);
        cycle(1, 3'b000, 0, 0, 32'd9, 32'd9, 0, 1, 0);
        idle(3, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic, starts mostly issued when idle
        for (int i = 0; i < 600; i++) begin
            if (m_left == 0) begin
                st = ($urandom_range(0, 3) == 0);
                hw = ($urandom_range(0, 5) == 0);
                lw = ($urandom_range(0, 5) == 0);
            end else begin
                st = ($urandom_range(0, 60) == 0);
                hw = 0;
                lw = 0;
            end
            fl = ($urandom_range(0, 9) == 0);
            cycle(st, 3'($urandom_range(0, 3)), hw, lw, pick_operand(), pick_operand(), fl,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 120) == 0));
        end
        idle(DIV_LAT + 2, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
